// File: rtl/hdmi_sched_pkg.sv
// Shared types and 720p timing constants for the HDMI scanout scheduler.
// Contents: fetch FSM state enum, pixel type, geometry localparams, and
//           helpers that map the current video line to the row it prefetches.
package hdmi_sched_pkg;

   localparam int H_ACTIVE = 1280;
   localparam int H_TOTAL  = 1650;
   localparam int V_ACTIVE = 720;
   localparam int V_TOTAL  = 750;
   localparam int DW       = 24;
   localparam int AW       = 20;
   localparam int SXW      = 11;
   localparam int SYW      = 10;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;

   typedef logic [DW-1:0] pixel_t;

   // A line prefetches the next row; the last blanking line prefetches row 0
   // so it is ready for the first active line of the next frame.
   function automatic logic has_target(input logic [SYW-1:0] y);
      return (y < SYW'(V_ACTIVE-1)) || (y == SYW'(V_TOTAL-1));
   endfunction

   function automatic logic [SYW-1:0] target_row(input logic [SYW-1:0] y);
      return (y == SYW'(V_TOTAL-1)) ? '0 : y + SYW'(1);
   endfunction

endpackage

// File: rtl/hdmi_line_buf.sv
// Ping-pong line buffer: two banks of H_ACTIVE pixels, one write port and
// one registered read port (rd_dat valid the cycle after rd_en).
// Ports: clk_pix; wr_en/wr_bank/wr_idx/wr_dat; rd_en/rd_bank/rd_idx -> rd_dat.
module hdmi_line_buf
   import hdmi_sched_pkg::*;
(
   input  logic           clk_pix,
   input  logic           wr_en,
   input  logic           wr_bank,
   input  logic [SXW-1:0] wr_idx,
   input  pixel_t         wr_dat,
   input  logic           rd_en,
   input  logic           rd_bank,
   input  logic [SXW-1:0] rd_idx,
   output pixel_t         rd_dat
);

   pixel_t mem [2][H_ACTIVE];

   always_ff @(posedge clk_pix) begin
      if (wr_en) begin
         mem[wr_bank][wr_idx] <= wr_dat;
      end
      if (rd_en) begin
         rd_dat <= mem[rd_bank][rd_idx];
      end
   end

endmodule

// File: rtl/hdmi_scanout_sched.sv
// Frame-memory scheduler for 720p scanout: display line prefetch has priority
// over the pixel writer, which is served in every cycle the fetch leaves free.
// Ports: clk_pix/rst_pix; sx/sy/de/hsync/vsync timing in; mem_* single-port
//        memory master; wr_* writer slave; pix_rgb/de_o/hsync_o/vsync_o
//        scanout (1-cycle delay); fetch_busy. Optional SCANOUT_UNDERRUN_EN
//        adds sticky underrun flag and underrun_row (row of first abort).
module hdmi_scanout_sched
   import hdmi_sched_pkg::*;
(
   input  logic           clk_pix,
   input  logic           rst_pix,
   input  logic [SXW-1:0] sx,
   input  logic [SYW-1:0] sy,
   input  logic           de,
   input  logic           hsync,
   input  logic           vsync,
   output logic           mem_req,
   input  logic           mem_gnt,
   output logic           mem_we,
   output logic [AW-1:0]  mem_addr,
   output logic [DW-1:0]  mem_wdata,
   input  logic           mem_rvalid,
   input  logic [DW-1:0]  mem_rdata,
   input  logic           wr_valid,
   input  logic [AW-1:0]  wr_addr,
   input  logic [DW-1:0]  wr_data,
   output logic           wr_ready,
   output logic [DW-1:0]  pix_rgb,
   output logic           de_o,
   output logic           hsync_o,
   output logic           vsync_o,
   output logic           fetch_busy
`ifdef SCANOUT_UNDERRUN_EN
   ,
   output logic           underrun,
   output logic [SYW-1:0] underrun_row
`endif
);

   fetch_state_t   state, state_nx;
   logic [SXW-1:0] col;         // reads accepted so far in this fetch
   logic [SXW-1:0] beats;       // read beats returned so far
   logic [AW-1:0]  row_base;    // word address of the row being fetched
   logic           fetch_bank;
   logic           de_d;
   pixel_t         rd_dat;

   logic [SYW-1:0] tgt_row;
   logic [AW-1:0]  start_base;
   logic           fetch_start;
   logic           fetching;
   logic           last_accept;
   logic           beat;
   logic           drain_done;
   logic           sx_last;
   logic           abort;

   assign tgt_row    = target_row(sy);
   // Row base advances by one line per fetched row, so no multiplier is needed.
   assign start_base = (tgt_row == '0) ? '0 : row_base + AW'(H_ACTIVE);

   // The first read goes out in the sx==0 cycle itself, so a full line of
   // reads fits in sx=0..H_ACTIVE-1 when the memory grants every cycle.
   assign fetch_start = !rst_pix && (state == IDLE) && (sx == '0) && has_target(sy);
   assign fetching    = fetch_start || (state == FETCH);
   assign last_accept = (state == FETCH) && mem_gnt && (col == SXW'(H_ACTIVE-1));

   // Read data arriving while idle belongs to an aborted fetch and is dropped.
   assign beat       = mem_rvalid && (state != IDLE);
   assign drain_done = (state == DRAIN) && beat && (beats == SXW'(H_ACTIVE-1));
   assign sx_last    = (sx == SXW'(H_TOTAL-1));
   assign abort      = sx_last && ((state == FETCH) || ((state == DRAIN) && !drain_done));

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      wr_ready  = 1'b0;

      case (state)
         IDLE:    if (fetch_start) state_nx = FETCH;
         FETCH:   if (abort) state_nx = IDLE;
                  else if (last_accept) state_nx = DRAIN;
         DRAIN:   if (abort || drain_done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      // Outputs are forced low while reset is held, including the
      // combinational writer path.
      if (!rst_pix) begin
         if (fetching) begin
            mem_req  = 1'b1;
            mem_addr = fetch_start ? start_base : row_base + AW'(col);
         end else begin
            wr_ready = mem_gnt;
            if (wr_valid) begin
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = wr_addr;
               mem_wdata = wr_data;
            end
         end
      end
   end

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         col        <= '0;
         beats      <= '0;
         row_base   <= '0;
         fetch_bank <= 1'b0;
      end else begin
         if (fetch_start) begin
            row_base   <= start_base;
            fetch_bank <= tgt_row[0];
            col        <= mem_gnt ? SXW'(1) : '0;
         end else if ((state == FETCH) && mem_gnt) begin
            col <= col + SXW'(1);
         end

         if (fetch_start) begin
            beats <= '0;
         end else if (beat) begin
            beats <= beats + SXW'(1);
         end
      end
   end

   // Fetch writes bank r[0] while display reads bank sy[0]; since r is the
   // row after sy (or row 0 from line V_TOTAL-1), the banks never collide.
   hdmi_line_buf u_line_buf (
      .clk_pix (clk_pix),
      .wr_en   (beat),
      .wr_bank (fetch_bank),
      .wr_idx  (beats),
      .wr_dat  (mem_rdata),
      .rd_en   (de),
      .rd_bank (sy[0]),
      .rd_idx  (sx),
      .rd_dat  (rd_dat)
   );

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         de_d    <= 1'b0;
         hsync_o <= 1'b0;
         vsync_o <= 1'b0;
      end else begin
         de_d    <= de;
         hsync_o <= hsync;
         vsync_o <= vsync;
      end
   end

   assign de_o       = de_d;
   assign pix_rgb    = de_d ? rd_dat : '0;
   assign fetch_busy = (state != IDLE);

`ifdef SCANOUT_UNDERRUN_EN
   logic [SYW-1:0] fetch_row;
   logic           underrun_r;
   logic [SYW-1:0] underrun_row_r;

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         fetch_row      <= '0;
         underrun_r     <= 1'b0;
         underrun_row_r <= '0;
      end else begin
         if (fetch_start) begin
            fetch_row <= tgt_row;
         end
         // Only the first abort is recorded; the flag is sticky until reset.
         if (abort && !underrun_r) begin
            underrun_r     <= 1'b1;
            underrun_row_r <= fetch_row;
         end
      end
   end

   assign underrun     = underrun_r;
   assign underrun_row = underrun_row_r;
`endif

endmodule

// File: tb/tb_hdmi_scanout_sched.sv
// Directed bench for hdmi_scanout_sched: drives 720p timing, models a
// latency-1 frame memory whose read data is a function of the address,
// and checks fetch addressing, scanout, writer arbitration, abort and reset.
module tb_hdmi_scanout_sched;

   logic        clk_pix;
   logic        rst_pix;
   logic [10:0] sx;
   logic [9:0]  sy;
   logic        de, hsync, vsync;
   logic        mem_req, mem_gnt, mem_we;
   logic [19:0] mem_addr;
   logic [23:0] mem_wdata;
   logic        mem_rvalid;
   logic [23:0] mem_rdata;
   logic        wr_valid;
   logic [19:0] wr_addr;
   logic [23:0] wr_data;
   logic        wr_ready;
   logic [23:0] pix_rgb;
   logic        de_o, hsync_o, vsync_o;
   logic        fetch_busy;
`ifdef SCANOUT_UNDERRUN_EN
   logic        underrun;
   logic [9:0]  underrun_row;
`endif

   hdmi_scanout_sched dut (
      .clk_pix    (clk_pix),
      .rst_pix    (rst_pix),
      .sx         (sx),
      .sy         (sy),
      .de         (de),
      .hsync      (hsync),
      .vsync      (vsync),
      .mem_req    (mem_req),
      .mem_gnt    (mem_gnt),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .wr_valid   (wr_valid),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .pix_rgb    (pix_rgb),
      .de_o       (de_o),
      .hsync_o    (hsync_o),
      .vsync_o    (vsync_o),
      .fetch_busy (fetch_busy)
`ifdef SCANOUT_UNDERRUN_EN
      ,
      .underrun     (underrun),
      .underrun_row (underrun_row)
`endif
   );

   initial begin
      clk_pix = 1'b0;
      forever #5 clk_pix = ~clk_pix;
   end

   int checks = 0;
   int errors = 0;

   int sx_i, sy_i;
   int p_sx, p_sy;
   logic p_de, p_hs, p_vs;
   logic gnt_toggle;
   logic check_pix;
   logic acc_rd;
   logic [19:0] acc_addr;

   // per-window statistics
   int req_cnt, req_first_sx, req_last_sx, rdy_in_fetch;
   int rd_acc_cnt, first_addr, last_addr, seq_bad;
   int wr_acc_cnt, wr_bad;
   int last_busy_sx;
   int pix_cnt, pix_bad;
   // whole-run statistics
   int zero_bad = 0;
   int strobe_bad = 0;

   function automatic logic [23:0] pat(input int a);
      logic [19:0] t;
      t = a[19:0];
      return {4'h5, t};
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive();
      sx    = sx_i[10:0];
      sy    = sy_i[9:0];
      de    = (sx_i < 1280) && (sy_i < 720);
      hsync = (sx_i >= 1390) && (sx_i < 1430);
      vsync = (sy_i >= 725) && (sy_i < 730);
   endtask

   task automatic clr();
      req_cnt = 0; req_first_sx = -1; req_last_sx = -1; rdy_in_fetch = 0;
      rd_acc_cnt = 0; first_addr = -1; last_addr = -1; seq_bad = 0;
      wr_acc_cnt = 0; wr_bad = 0; last_busy_sx = -1;
      pix_cnt = 0; pix_bad = 0;
   endtask

   // One clock: sample mid-cycle, then after the edge answer reads and
   // advance the timing counters.
   task automatic step();
      #4;
      acc_rd   = 1'b0;
      acc_addr = mem_addr;
      if (!rst_pix) begin
         if (mem_req && !mem_we) begin
            req_cnt++;
            if (req_first_sx < 0) req_first_sx = sx_i;
            req_last_sx = sx_i;
            if (wr_ready) rdy_in_fetch++;
         end
         if (mem_req && mem_gnt && !mem_we) begin
            acc_rd = 1'b1;
            if (rd_acc_cnt == 0) first_addr = int'(mem_addr);
            else if (int'(mem_addr) !== first_addr + rd_acc_cnt) seq_bad++;
            last_addr = int'(mem_addr);
            rd_acc_cnt++;
         end
         if (mem_req && mem_gnt && mem_we) begin
            wr_acc_cnt++;
            if (mem_addr !== wr_addr || mem_wdata !== wr_data || wr_ready !== 1'b1) wr_bad++;
         end
         if (fetch_busy) last_busy_sx = sx_i;
         if (de_o !== p_de || hsync_o !== p_hs || vsync_o !== p_vs) strobe_bad++;
         if (de_o !== 1'b1 && pix_rgb !== 24'h0) zero_bad++;
         if (check_pix && de_o) begin
            pix_cnt++;
            if (pix_rgb !== pat(p_sy * 1280 + p_sx)) pix_bad++;
         end
      end
      @(posedge clk_pix);
      #1;
      mem_rvalid = acc_rd;
      mem_rdata  = acc_rd ? pat(int'(acc_addr)) : 24'h0;
      p_de = rst_pix ? 1'b0 : de;
      p_hs = rst_pix ? 1'b0 : hsync;
      p_vs = rst_pix ? 1'b0 : vsync;
      p_sx = sx_i;
      p_sy = sy_i;
      if (sx_i == 1649) begin
         sx_i = 0;
         sy_i = (sy_i == 749) ? 0 : sy_i + 1;
      end else begin
         sx_i++;
      end
      if (gnt_toggle) mem_gnt = ~mem_gnt;
      drive();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic jump(input int y);
      sx_i = 0;
      sy_i = y;
      drive();
   endtask

   initial begin
      rst_pix = 1'b1; mem_gnt = 1'b1; wr_valid = 1'b0;
      wr_addr = 20'h12345; wr_data = 24'hABCDEF;
      mem_rvalid = 1'b0; mem_rdata = 24'h0;
      gnt_toggle = 1'b0; check_pix = 1'b0;
      p_de = 1'b0; p_hs = 1'b0; p_vs = 1'b0; p_sx = 0; p_sy = 0;
      sx_i = 0; sy_i = 0; drive();
      clr();
      repeat (3) @(posedge clk_pix);
      #1;

      // reset state
      chk("rst_mem_req", int'(mem_req), 0);
      chk("rst_fetch_busy", int'(fetch_busy), 0);
      chk("rst_pix_rgb", int'(pix_rgb), 0);
      chk("rst_de_o", int'(de_o), 0);
      chk("rst_wr_ready", int'(wr_ready), 0);
`ifdef SCANOUT_UNDERRUN_EN
      chk("rst_underrun", int'(underrun), 0);
`endif

      // 1: line 0 prefetches row 1 with a grant every cycle
      rst_pix = 1'b0;
      jump(0);
      clr();
      run(1650);
      chk("t1_reads", rd_acc_cnt, 1280);
      chk("t1_first_addr", first_addr, 1280);
      chk("t1_last_addr", last_addr, 2559);
      chk("t1_addr_seq", seq_bad, 0);
      chk("t1_req_first_sx", req_first_sx, 0);
      chk("t1_req_last_sx", req_last_sx, 1279);
      chk("t1_busy_fall", int'(last_busy_sx <= 1280 && last_busy_sx >= 1279), 1);

      // line 1 shows row 1
      clr();
      check_pix = 1'b1;
      run(1650);
      check_pix = 1'b0;
      chk("t1_pix_cnt", pix_cnt, 1280);
      chk("t1_pix_data", pix_bad, 0);
      chk("t1_row2_addr", first_addr, 2560);

      // 2: last blanking line prefetches row 0 into bank 0
      jump(749);
      clr();
      run(1650);
      chk("t2_reads", rd_acc_cnt, 1280);
      chk("t2_first_addr", first_addr, 0);
      chk("t2_last_addr", last_addr, 1279);
      clr();
      check_pix = 1'b1;
      run(1650);
      check_pix = 1'b0;
      chk("t2_pix_cnt", pix_cnt, 1280);
      chk("t2_pix_data", pix_bad, 0);

      // lines 720..748 start no fetch
      clr();
      for (int s = 720; s <= 748; s++) begin
         jump(s);
         step();
      end
      chk("t2_blank_req", req_cnt, 0);
      chk("t2_blank_busy", int'(fetch_busy), 0);

      // 3: writer active for the whole line
      jump(5);
      wr_valid = 1'b1;
      clr();
      run(1650);
      wr_valid = 1'b0;
      chk("t3_rdy_in_fetch", rdy_in_fetch, 0);
      chk("t3_wr_min", int'(wr_acc_cnt >= 368), 1);
      chk("t3_wr_fields", wr_bad, 0);
      chk("t3_reads", rd_acc_cnt, 1280);

      // 4: half-rate grant cannot finish the line -> abort
`ifdef SCANOUT_UNDERRUN_EN
      chk("t4_underrun_pre", int'(underrun), 0);
`endif
      jump(10);
      mem_gnt = 1'b1;
      gnt_toggle = 1'b1;
      clr();
      run(1649);
      chk("t4_busy_at_1649", int'(fetch_busy), 1);
      chk("t4_reads", rd_acc_cnt, 825);
      step();
      chk("t4_busy_after", int'(fetch_busy), 0);
      gnt_toggle = 1'b0;
      mem_gnt = 1'b1;
      clr();
      run(1650);
      chk("t4_recover_reads", rd_acc_cnt, 1280);
`ifdef SCANOUT_UNDERRUN_EN
      chk("t4_underrun", int'(underrun), 1);
      chk("t4_underrun_row", int'(underrun_row), 11);
`endif

      // 5: reset pulse in the middle of a fetch
      jump(20);
      clr();
      run(600);
      chk("t5_busy_pre", int'(fetch_busy), 1);
      wr_valid = 1'b1;
      rst_pix = 1'b1;
      #1;
      chk("t5_mem_req", int'(mem_req), 0);
      chk("t5_fetch_busy", int'(fetch_busy), 0);
      chk("t5_wr_ready", int'(wr_ready), 0);
      chk("t5_pix_rgb", int'(pix_rgb), 0);
      chk("t5_de_o", int'(de_o), 0);
`ifdef SCANOUT_UNDERRUN_EN
      chk("t5_underrun", int'(underrun), 0);
`endif
      run(3);
      wr_valid = 1'b0;
      rst_pix = 1'b0;
      clr();
      for (int i = 0; i < 1650 && sx_i != 0; i++) step();
      chk("t5_reach_sx0", sx_i, 0);
      chk("t5_no_early_req", req_cnt, 0);
      clr();
      run(1650);
      chk("t5_restart_reads", rd_acc_cnt, 1280);
      chk("t5_restart_sx", req_first_sx, 0);

      chk("strobe_delay", strobe_bad, 0);
      chk("pix_zero_blank", zero_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
